// File: rtl/hbm_val_reader.sv
// AXI4 read master that fetches a job of num_beats 32-byte beats from HBM and streams them out on AXIS.
// Optional beat_cnt statistics port is enabled by defining HBM_VAL_READER_STATS_EN.
module hbm_val_reader #(
    parameter int ADDR_W          = 48,
    parameter int DATA_W          = 256,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              axis_clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       num_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic              m_axi_rlast,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
`ifdef HBM_VAL_READER_STATS_EN
    ,
    output logic [31:0]       beat_cnt
`endif
);

    localparam int DEPTH = MAX_OUTSTANDING * MAX_BURST;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       remain_q;
    logic [31:0]       out_left_q;
    logic              arvalid_q;
    logic [7:0]        arlen_q;
    logic [31:0]       len_q;
    logic              err_q;
    logic              done_q;
    logic              zero_job_q;

    logic [CNT_W-1:0]  resv_q, resv_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ar_hs, push, pop, start_acc, credit_ok;
    logic [31:0]       next_len, start_len;
    logic              unused_rlast;

    // Burst length is capped by what is left, MAX_BURST, and the beats remaining in the current 4 KB page.
    function automatic logic [31:0] burst_len(input logic [ADDR_W-1:0] addr, input logic [31:0] rem);
        logic [31:0] to_4k;
        logic [31:0] len;
        to_4k = 32'd128 - {25'd0, addr[11:5]};
        len   = rem;
        if (len > 32'(MAX_BURST)) len = 32'(MAX_BURST);
        if (len > to_4k) len = to_4k;
        return len;
    endfunction

    assign ar_hs     = arvalid_q && m_axi_arready;
    assign push      = m_axi_rvalid && m_axi_rready;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign start_acc = (state_q == IDLE) && start;
    assign next_len  = burst_len(addr_q, remain_q);
    assign start_len = burst_len(base_addr, num_beats);
    assign credit_ok = (32'(resv_q) + next_len) <= 32'(DEPTH);

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'd5;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q != IDLE);
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = mem[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && (out_left_q == 32'd1);
    assign unused_rlast  = m_axi_rlast;

    // Slots are reserved for a whole burst when its AR is accepted and given back one per AXIS beat.
    assign resv_d  = resv_q + (ar_hs ? CNT_W'(len_q) : '0) - (pop ? CNT_W'(1) : '0);
    assign count_d = count_q + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);

    always_ff @(posedge axis_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            out_left_q <= '0;
            arvalid_q  <= 1'b0;
            arlen_q    <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            zero_job_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push && m_axi_rresp != 2'b00) err_q <= 1'b1;
            if (pop) out_left_q <= out_left_q - 32'd1;
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        err_q      <= 1'b0;
                        addr_q     <= base_addr;
                        remain_q   <= num_beats;
                        out_left_q <= num_beats;
                        if (num_beats == 32'd0) begin
                            state_q    <= DONE;
                            zero_job_q <= 1'b1;
                        end else begin
                            state_q   <= ISSUE;
                            arvalid_q <= 1'b1;
                            len_q     <= start_len;
                            arlen_q   <= 8'(start_len - 32'd1);
                        end
                    end
                end
                ISSUE: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        addr_q    <= addr_q + (ADDR_W'(len_q) << 5);
                        remain_q  <= remain_q - len_q;
                        if (remain_q == len_q) state_q <= DRAIN;
                    end else if (!arvalid_q && credit_ok) begin
                        arvalid_q <= 1'b1;
                        len_q     <= next_len;
                        arlen_q   <= 8'(next_len - 32'd1);
                    end
                end
                DRAIN: begin
                    if (pop && out_left_q == 32'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // An empty job reports completion one cycle later, on the way back to IDLE.
                    state_q    <= IDLE;
                    done_q     <= zero_job_q;
                    zero_job_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            resv_q   <= '0;
        end else begin
            count_q <= count_d;
            resv_q  <= resv_d;
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr_q] <= m_axi_rdata;
    end

`ifdef HBM_VAL_READER_STATS_EN
    logic [31:0] beat_cnt_q;

    always_ff @(posedge axis_clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q <= '0;
        end else if (start_acc) begin
            beat_cnt_q <= '0;
        end else if (pop && beat_cnt_q != 32'hFFFF_FFFF) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_hbm_val_reader.sv
// Directed bench for hbm_val_reader: AXI read slave model, AXIS sink and a scoreboard of expected beats/ARs.
module tb_hbm_val_reader;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 256;

    logic              clk = 1'b0;
    logic              rstn, start, busy, done, err;
    logic [ADDR_W-1:0] base_addr, araddr;
    logic [31:0]       num_beats;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst, rresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] rdata, tdata;
    logic              tvalid, tlast, tready;
`ifdef HBM_VAL_READER_STATS_EN
    logic [31:0]       beat_cnt;
`endif

    hbm_val_reader dut (
        .axis_clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .err(err),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rlast(rlast), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready)
`ifdef HBM_VAL_READER_STATS_EN
        , .beat_cnt(beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] exp_addr[$], rbeats[$], ar_addr_log[$];
    logic [7:0]        exp_len[$], ar_len_log[$];
    logic              rlastq[$], sb_last[$];
    logic [DATA_W-1:0] sb_data[$];

    int   ar_cnt = 0, beats_rx = 0, done_cnt = 0;
    int   ar0, bx0, dn0, start_cyc, first_ar_cyc, last_hs_cyc, done_cyc;
    logic first_ar_seen = 1'b0, err_at_done = 1'b0, r_fire_n = 1'b0;
    int   beat_seq = 0, err_at = -1;
    logic ar_rand = 1'b0, r_rand = 1'b0, t_rand = 1'b0, t_level = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = a[31:0] ^ 32'h5A5A_0000;
        return {(DATA_W/32){w}};
    endfunction

    // Expected beats and AR bursts for a job: split by remaining, 16 beats and 4 KB pages.
    task automatic build_exp(input logic [ADDR_W-1:0] base, input int n);
        logic [ADDR_W-1:0] a;
        int rem, to4k, len;
        for (int i = 0; i < n; i++) begin
            sb_data.push_back(data_of(base + ADDR_W'(i * 32)));
            sb_last.push_back(i == n - 1);
        end
        a   = base;
        rem = n;
        while (rem > 0) begin
            to4k = (4096 - int'(a[11:0])) / 32;
            len  = rem;
            if (len > 16) len = 16;
            if (len > to4k) len = to4k;
            exp_addr.push_back(a);
            exp_len.push_back(8'(len - 1));
            a   = a + ADDR_W'(len * 32);
            rem = rem - len;
        end
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] base, input int n);
        build_exp(base, n);
        first_ar_seen = 1'b0;
        beat_seq      = 0;
        ar_addr_log.delete();
        ar_len_log.delete();
        ar0 = ar_cnt; bx0 = beats_rx; dn0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_beats = 32'(n); start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && done_cnt == dn0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 64'(done_cnt - dn0), 64'd1);
    endtask

    // Observe handshakes mid-cycle, where every signal is settled.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [7:0]        el;
        r_fire_n = rvalid && rready;
        if (arvalid && !first_ar_seen) begin
            first_ar_seen = 1'b1;
            first_ar_cyc  = cyc;
        end
        if (arvalid && arready) begin
            ar_cnt++;
            ar_addr_log.push_back(araddr);
            ar_len_log.push_back(arlen);
            chk("ar_size", 64'(arsize), 64'd5);
            chk("ar_burst", 64'(arburst), 64'd1);
            chk("ar_expected", 64'(exp_addr.size() != 0), 64'd1);
            if (exp_addr.size() != 0) begin
                ea = exp_addr.pop_front();
                el = exp_len.pop_front();
                chk("ar_addr", 64'(araddr), 64'(ea));
                chk("ar_len", 64'(arlen), 64'(el));
            end
            for (int i = 0; i <= int'(arlen); i++) begin
                rbeats.push_back(araddr + ADDR_W'(i * 32));
                rlastq.push_back(i == int'(arlen));
            end
        end
        if (tvalid && tready) begin
            beats_rx++;
            chk("axis_expected", 64'(sb_data.size() != 0), 64'd1);
            if (sb_data.size() != 0) begin
                chkd("axis_data", tdata, sb_data.pop_front());
                chk("axis_last", 64'(tlast), 64'(sb_last.pop_front()));
            end
            if (tlast) last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = err;
        end
    end

    // AXI read slave and AXIS sink drivers.
    always @(posedge clk) begin
        #1;
        if (r_fire_n && rbeats.size() != 0) begin
            void'(rbeats.pop_front());
            void'(rlastq.pop_front());
            beat_seq++;
        end
        r_fire_n = 1'b0;
        if (rbeats.size() != 0 && (!r_rand || $urandom_range(0, 3) != 0)) begin
            rvalid = 1'b1;
            rdata  = data_of(rbeats[0]);
            rlast  = rlastq[0];
            rresp  = (beat_seq == err_at) ? 2'd2 : 2'd0;
        end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'd0;
        end
        arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        tready  = t_rand ? 1'($urandom_range(0, 1)) : t_level;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0;
        arready = 1'b1; tready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Single aligned 16-beat job
        run_job(48'h0, 16);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done", 300);
        chk("t1_ar_count", 64'(ar_cnt - ar0), 64'd1);
        chk("t1_first_ar_lat", 64'(first_ar_cyc - start_cyc), 64'd1);
        chk("t1_done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
        chk("t1_beats", 64'(beats_rx - bx0), 64'd16);
        chk("t1_err", 64'(err), 64'd0);
`ifdef HBM_VAL_READER_STATS_EN
        chk("t1_beat_cnt", 64'(beat_cnt), 64'd16);
`endif

        // 4 KB page split
        run_job(48'hFC0, 8);
        wait_done("t2_done", 300);
        chk("t2_ar_count", 64'(ar_cnt - ar0), 64'd2);
        if (ar_addr_log.size() == 2) begin
            chk("t2_ar0_addr", 64'(ar_addr_log[0]), 64'hFC0);
            chk("t2_ar0_len", 64'(ar_len_log[0]), 64'd1);
            chk("t2_ar1_addr", 64'(ar_addr_log[1]), 64'h1000);
            chk("t2_ar1_len", 64'(ar_len_log[1]), 64'd5);
        end

        // Back-pressure: credit limits outstanding bursts to the FIFO depth
        t_level = 1'b0;
        run_job(48'h2000, 100);
        repeat (200) @(posedge clk);
        #1;
        chk("t3_ar_stalled", 64'(ar_cnt - ar0), 64'd4);
        chk("t3_tvalid", 64'(tvalid), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_no_beats", 64'(beats_rx - bx0), 64'd0);
        t_level = 1'b1;
        wait_done("t3_done", 1000);
        chk("t3_beats", 64'(beats_rx - bx0), 64'd100);
        chk("t3_ar_total", 64'(ar_cnt - ar0), 64'd7);

        // Error response on the third beat
        err_at = 2;
        run_job(48'h4000, 16);
        wait_done("t4_done", 300);
        chk("t4_err_at_done", 64'(err_at_done), 64'd1);
        chk("t4_err_sticky", 64'(err), 64'd1);
        err_at = -1;

        // Random handshakes across a page boundary; the new start clears err
        ar_rand = 1'b1; r_rand = 1'b1; t_rand = 1'b1;
        run_job(48'h1F80, 40);
        chk("t5_err_cleared", 64'(err), 64'd0);
        wait_done("t5_done", 3000);
        chk("t5_beats", 64'(beats_rx - bx0), 64'd40);
        chk("t5_ar_total", 64'(ar_cnt - ar0), 64'd4);
        ar_rand = 1'b0; r_rand = 1'b0; t_rand = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset with bursts outstanding
        t_level = 1'b0;
        err_at  = 0;
        run_job(48'h6000, 100);
        for (int i = 0; i < 50 && (ar_cnt - ar0) < 2; i++) @(posedge clk);
        #2;
        chk("t6_two_ar", 64'(ar_cnt - ar0), 64'd2);
        chk("t6_err_pre", 64'(err), 64'd1);
        chk("t6_tvalid_pre", 64'(tvalid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("t6_arvalid", 64'(arvalid), 64'd0);
        chk("t6_tvalid", 64'(tvalid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        sb_data.delete(); sb_last.delete(); exp_addr.delete(); exp_len.delete();
        rbeats.delete(); rlastq.delete();
        rvalid = 1'b0; err_at = -1; t_level = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        ar0 = ar_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_ar_after_rst", 64'(ar_cnt - ar0), 64'd0);
        chk("t6_idle_after_rst", 64'(busy), 64'd0);
        run_job(48'h8000, 4);
        wait_done("t6_fresh_done", 300);
        chk("t6_fresh_beats", 64'(beats_rx - bx0), 64'd4);
        chk("t6_fresh_ar", 64'(ar_cnt - ar0), 64'd1);

        // Empty job
        run_job(48'h100, 0);
        wait_done("t7_done", 50);
        chk("t7_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        chk("t7_no_ar", 64'(ar_cnt - ar0), 64'd0);
        chk("t7_no_beats", 64'(beats_rx - bx0), 64'd0);
`ifdef HBM_VAL_READER_STATS_EN
        chk("t7_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
        chk("end_sb_empty", 64'(sb_data.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
